// File: rtl/avalon_bus_arbiter_if.sv
// Avalon-MM port bundle shared by the arbiter's master and slave sides.
// The master modport is the side that issues transfers.
interface avalon_bus_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   address;
    logic                read;
    logic                write;
    logic [DATA_W-1:0]   writedata;
    logic [DATA_W/8-1:0] byteenable;
    logic [DATA_W-1:0]   readdata;
    logic                waitrequest;

    modport master (
        output address, read, write,
        output writedata, byteenable,
        input  readdata, waitrequest
    );

    modport slave (
        input  address, read, write,
        input  writedata, byteenable,
        output readdata, waitrequest
    );
endinterface

// File: rtl/avalon_bus_arbiter.sv
// Round-robin arbiter sharing one Avalon-MM RAM port between
// the fetch (m0) and load/store (m1) masters, with stall watchdog.
module avalon_bus_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 1000
) (
    input  logic                 clk,
    input  logic                 reset,
    avalon_bus_arbiter_if.slave  m0,
    avalon_bus_arbiter_if.slave  m1,
    avalon_bus_arbiter_if.master s,
    output logic [1:0]           grant,
    output logic                 bus_error
);
    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] GNT0 = 2'b01;
    localparam logic [1:0] GNT1 = 2'b10;

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'(TIMEOUT - 1);

    logic [1:0]          state;
    logic                last_ptr;
    logic [CNT_W-1:0]    stall_cnt;
    logic                req0;
    logic                req1;
    logic                cur;
    logic                cur_req;

    logic [ADDR_W-1:0]   sel_addr;
    logic                sel_rd;
    logic                sel_wr;
    logic [DATA_W-1:0]   sel_wdata;
    logic [DATA_W/8-1:0] sel_be;
    logic                wait0;
    logic                wait1;

    assign req0    = m0.read | m0.write;
    assign req1    = m1.read | m1.write;
    assign cur     = (state == GNT1);
    assign cur_req = cur ? req1 : req0;

    // Write wins when a master raises read and write together.
    always_comb begin
        sel_addr  = '0;
        sel_rd    = 1'b0;
        sel_wr    = 1'b0;
        sel_wdata = '0;
        sel_be    = '0;
        wait0     = req0;
        wait1     = req1;
        unique case (state)
            GNT0: begin
                sel_addr  = m0.address;
                sel_rd    = m0.read & ~m0.write;
                sel_wr    = m0.write;
                sel_wdata = m0.writedata;
                sel_be    = m0.byteenable;
                wait0     = s.waitrequest;
            end
            GNT1: begin
                sel_addr  = m1.address;
                sel_rd    = m1.read & ~m1.write;
                sel_wr    = m1.write;
                sel_wdata = m1.writedata;
                sel_be    = m1.byteenable;
                wait1     = s.waitrequest;
            end
            default: ;
        endcase
        if (!reset) begin
            sel_addr  = '0;
            sel_rd    = 1'b0;
            sel_wr    = 1'b0;
            sel_wdata = '0;
            sel_be    = '0;
            wait0     = 1'b1;
            wait1     = 1'b1;
        end
    end

    assign s.address      = sel_addr;
    assign s.read         = sel_rd;
    assign s.write        = sel_wr;
    assign s.writedata    = sel_wdata;
    assign s.byteenable   = sel_be;
    assign m0.waitrequest = wait0;
    assign m1.waitrequest = wait1;
    assign m0.readdata    = s.readdata;
    assign m1.readdata    = s.readdata;
    assign grant          = reset ? state : IDLE;

    // last_ptr names the master served most recently; a tie goes
    // to the other one.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            last_ptr  <= 1'b1;
            stall_cnt <= '0;
            bus_error <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    stall_cnt <= '0;
                    if (req0 && (!req1 || last_ptr))
                        state <= GNT0;
                    else if (req1)
                        state <= GNT1;
                end
                GNT0, GNT1: begin
                    if (!cur_req) begin
                        state     <= IDLE;
                        stall_cnt <= '0;
                    end else if (!s.waitrequest) begin
                        state     <= IDLE;
                        last_ptr  <= cur;
                        stall_cnt <= '0;
                    end else if (stall_cnt == CNT_LAST) begin
                        state     <= IDLE;
                        last_ptr  <= cur;
                        stall_cnt <= '0;
                        bus_error <= 1'b1;
                    end else begin
                        stall_cnt <= stall_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state     <= IDLE;
                    stall_cnt <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_avalon_bus_arbiter.sv
// Directed bench for avalon_bus_arbiter with a small RAM model
// whose wait states can be injected or held forever.
module tb_avalon_bus_arbiter;
    logic       clk;
    logic       reset;
    logic [1:0] grant;
    logic       bus_error;
    int         checks;
    int         errors;

    logic [31:0] mem [0:255];
    int          stall_left;
    logic        stuck;

    avalon_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) m0_if ();
    avalon_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) m1_if ();
    avalon_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) s_if ();

    avalon_bus_arbiter #(
        .ADDR_W(32), .DATA_W(32), .TIMEOUT(4)
    ) dut (
        .clk(clk), .reset(reset),
        .m0(m0_if), .m1(m1_if), .s(s_if),
        .grant(grant), .bus_error(bus_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        s_if.waitrequest = stuck || (stall_left != 0);
        s_if.readdata    = mem[s_if.address[9:2]];
    end

    always @(posedge clk) begin
        if ((s_if.read || s_if.write) && stall_left != 0)
            stall_left <= stall_left - 1;
        if (s_if.write && !s_if.waitrequest)
            for (int b = 0; b < 4; b++)
                if (s_if.byteenable[b])
                    mem[s_if.address[9:2]][8*b +: 8] <=
                        s_if.writedata[8*b +: 8];
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit hit");
        $fatal(1, "bench time limit");
    end

    task automatic idle_masters;
        m0_if.address = '0; m0_if.read = 0; m0_if.write = 0;
        m0_if.writedata = '0; m0_if.byteenable = '0;
        m1_if.address = '0; m1_if.read = 0; m1_if.write = 0;
        m1_if.writedata = '0; m1_if.byteenable = '0;
    endtask

    task automatic test_reset;
        reset = 0; stuck = 0; stall_left = 0;
        idle_masters();
        @(negedge clk); @(negedge clk);
        checks++; if (grant !== 2'b00) begin errors++;
            $display("FAIL rst_grant: got %b want 00", grant); end
        checks++; if (bus_error !== 1'b0) begin errors++;
            $display("FAIL rst_err: got %b want 0", bus_error); end
        checks++; if ({s_if.read, s_if.write} !== 2'b00) begin errors++;
            $display("FAIL rst_srw: got %b want 00",
                     {s_if.read, s_if.write}); end
        checks++;
        if ({m0_if.waitrequest, m1_if.waitrequest} !== 2'b11) begin
            errors++;
            $display("FAIL rst_wait: got %b want 11",
                     {m0_if.waitrequest, m1_if.waitrequest}); end
        reset = 1;
    endtask

    task automatic test_single_read;
        @(negedge clk);
        m0_if.address = 32'h4; m0_if.read = 1; #1;
        checks++; if (grant !== 2'b00) begin errors++;
            $display("FAIL t1_arb_grant: got %b want 00", grant); end
        checks++; if (m0_if.waitrequest !== 1'b1) begin errors++;
            $display("FAIL t1_arb_wait: got %b want 1",
                     m0_if.waitrequest); end
        @(negedge clk);
        checks++; if (grant !== 2'b01) begin errors++;
            $display("FAIL t1_grant: got %b want 01", grant); end
        checks++; if (m0_if.waitrequest !== 1'b0) begin errors++;
            $display("FAIL t1_wait: got %b want 0",
                     m0_if.waitrequest); end
        checks++; if (m0_if.readdata !== 32'h2403F0F0) begin errors++;
            $display("FAIL t1_data: got %h want 2403f0f0",
                     m0_if.readdata); end
        checks++;
        if (s_if.read !== 1'b1 || s_if.address !== 32'h4) begin
            errors++;
            $display("FAIL t1_sbus: got rd=%b a=%h want rd=1 a=4",
                     s_if.read, s_if.address); end
        @(posedge clk); #1 m0_if.read = 0;
        @(negedge clk);
        checks++; if (grant !== 2'b00) begin errors++;
            $display("FAIL t1_idle: got %b want 00", grant); end
        checks++; if (m0_if.waitrequest !== 1'b0) begin errors++;
            $display("FAIL t1_idle_wait: got %b want 0",
                     m0_if.waitrequest); end
    endtask

    task automatic test_both_from_reset;
        @(negedge clk);
        reset = 0;
        m0_if.address = 32'h4; m0_if.read = 1;
        m1_if.address = 32'h100; m1_if.write = 1;
        m1_if.writedata = 32'hDEADBEEF; m1_if.byteenable = 4'hF;
        #1;
        checks++; if (s_if.write !== 1'b0 || grant !== 2'b00) begin
            errors++;
            $display("FAIL t2_in_rst: got w=%b g=%b want 0 00",
                     s_if.write, grant); end
        @(negedge clk) reset = 1;
        @(negedge clk);
        checks++; if (grant !== 2'b01) begin errors++;
            $display("FAIL t2_first: got %b want 01", grant); end
        checks++; if (m1_if.waitrequest !== 1'b1) begin errors++;
            $display("FAIL t2_m1_wait: got %b want 1",
                     m1_if.waitrequest); end
        @(posedge clk); #1 m0_if.read = 0;
        @(negedge clk);
        checks++; if (grant !== 2'b00) begin errors++;
            $display("FAIL t2_arb: got %b want 00", grant); end
        @(negedge clk);
        checks++; if (grant !== 2'b10) begin errors++;
            $display("FAIL t2_second: got %b want 10", grant); end
        checks++;
        if (s_if.write !== 1'b1 || s_if.writedata !== 32'hDEADBEEF)
        begin
            errors++;
            $display("FAIL t2_sbus: got w=%b d=%h want 1 deadbeef",
                     s_if.write, s_if.writedata); end
        m0_if.read = 1; #1;
        checks++; if (m0_if.waitrequest !== 1'b1) begin errors++;
            $display("FAIL t2_m0_blocked: got %b want 1",
                     m0_if.waitrequest); end
        @(posedge clk); #1 m1_if.write = 0;
        @(negedge clk);
        checks++; if (mem[64] !== 32'hDEADBEEF) begin errors++;
            $display("FAIL t2_ram: got %h want deadbeef", mem[64]); end
        @(negedge clk);
        checks++; if (grant !== 2'b01) begin errors++;
            $display("FAIL t2_regrant: got %b want 01", grant); end
        @(posedge clk); #1 m0_if.read = 0;
        @(negedge clk);
    endtask

    task automatic test_round_robin;
        logic [1:0] exp;
        m0_if.address = 32'h0; m0_if.read = 1;
        m1_if.address = 32'h4; m1_if.read = 1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (i % 2 == 1) exp = 2'b00;
            else exp = ((i / 2) % 2 == 0) ? 2'b10 : 2'b01;
            checks++; if (grant !== exp) begin errors++;
                $display("FAIL t3_rr[%0d]: got %b want %b",
                         i, grant, exp); end
        end
        m0_if.read = 0; m1_if.read = 0;
    endtask

    task automatic test_wait_states;
        @(negedge clk);
        stall_left = 3;
        m1_if.address = 32'h10; m1_if.read = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (grant !== 2'b10 || m1_if.waitrequest !== 1'b1) begin
                errors++;
                $display("FAIL t4_stall[%0d]: got g=%b w=%b want 10 1",
                         i, grant, m1_if.waitrequest); end
        end
        @(negedge clk);
        checks++;
        if (m1_if.waitrequest !== 1'b0 ||
            m1_if.readdata !== 32'h12345678) begin
            errors++;
            $display("FAIL t4_accept: got w=%b d=%h want 0 12345678",
                     m1_if.waitrequest, m1_if.readdata); end
        @(posedge clk); #1 m1_if.read = 0;
        @(negedge clk);
        checks++; if (grant !== 2'b00 || bus_error !== 1'b0) begin
            errors++;
            $display("FAIL t4_done: got g=%b e=%b want 00 0",
                     grant, bus_error); end
    endtask

    task automatic test_watchdog;
        @(negedge clk);
        stuck = 1;
        m0_if.address = 32'h20; m0_if.write = 1;
        m0_if.writedata = 32'h55; m0_if.byteenable = 4'hF;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (grant !== 2'b01 || bus_error !== 1'b0) begin
                errors++;
                $display("FAIL t5_stall[%0d]: got g=%b e=%b want 01 0",
                         i, grant, bus_error); end
        end
        @(negedge clk);
        checks++; if (grant !== 2'b00 || bus_error !== 1'b1) begin
            errors++;
            $display("FAIL t5_abort: got g=%b e=%b want 00 1",
                     grant, bus_error); end
        checks++; if (m0_if.waitrequest !== 1'b1) begin errors++;
            $display("FAIL t5_abort_wait: got %b want 1",
                     m0_if.waitrequest); end
        @(negedge clk);
        checks++; if (grant !== 2'b01) begin errors++;
            $display("FAIL t5_rearb: got %b want 01", grant); end
        m0_if.write = 0; stuck = 0;
        @(negedge clk);
        checks++; if (grant !== 2'b00 || bus_error !== 1'b1) begin
            errors++;
            $display("FAIL t5_sticky: got g=%b e=%b want 00 1",
                     grant, bus_error); end
        checks++; if (mem[8] !== 32'h0) begin errors++;
            $display("FAIL t5_nowrite: got %h want 0", mem[8]); end
    endtask

    task automatic test_reset_mid_grant;
        @(negedge clk);
        stuck = 1;
        m1_if.address = 32'h40; m1_if.write = 1;
        m1_if.writedata = 32'hA5A5A5A5; m1_if.byteenable = 4'hF;
        @(negedge clk);
        checks++; if (grant !== 2'b10 || s_if.write !== 1'b1) begin
            errors++;
            $display("FAIL t6_pre: got g=%b w=%b want 10 1",
                     grant, s_if.write); end
        #2 reset = 0;
        #1;
        checks++;
        if (s_if.write !== 1'b0 || grant !== 2'b00 ||
            bus_error !== 1'b0) begin
            errors++;
            $display("FAIL t6_async: got w=%b g=%b e=%b want 0 00 0",
                     s_if.write, grant, bus_error); end
        checks++;
        if ({m0_if.waitrequest, m1_if.waitrequest} !== 2'b11 ||
            s_if.address !== 32'h0) begin
            errors++;
            $display("FAIL t6_outs: got w=%b a=%h want 11 0",
                     {m0_if.waitrequest, m1_if.waitrequest},
                     s_if.address); end
        m0_if.address = 32'h4; m0_if.read = 1; stuck = 0;
        @(negedge clk) reset = 1;
        @(negedge clk);
        checks++; if (grant !== 2'b01) begin errors++;
            $display("FAIL t6_tie: got %b want 01", grant); end
        @(posedge clk); #1 m0_if.read = 0;
        @(negedge clk);
        @(negedge clk);
        checks++; if (grant !== 2'b10) begin errors++;
            $display("FAIL t6_next: got %b want 10", grant); end
        @(posedge clk); #1 m1_if.write = 0;
        @(negedge clk);
    endtask

    initial begin
        checks = 0; errors = 0;
        for (int i = 0; i < 256; i++) mem[i] = '0;
        mem[1] = 32'h2403F0F0;
        mem[4] = 32'h12345678;
        test_reset();
        test_single_read();
        test_both_from_reset();
        test_round_robin();
        test_wait_states();
        test_watchdog();
        test_reset_mid_grant();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
